// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue unit: ALU opcodes, RV32I major
// opcodes, FSM states, operand-B select and branch condition kinds.
package alu_issue_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SLL  = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_XOR  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      BSEL_RS2,
      BSEL_IMM,
      BSEL_SHAMT_IMM,
      BSEL_SHAMT_RS2
   } bsel_e;

   typedef enum logic [2:0] {
      BR_EQ,
      BR_NE,
      BR_LT,
      BR_GE,
      BR_LTU,
      BR_GEU
   } br_e;

   // alt selects SUB over ADD and SRA over SRL (funct7[5])
   function automatic logic [3:0] alu_code(input logic [2:0] funct3, input logic alt);
      logic [3:0] code;
      case (funct3)
         3'b000:  code = alt ? ALU_SUB : ALU_ADD;
         3'b001:  code = ALU_SLL;
         3'b010:  code = ALU_SLT;
         3'b011:  code = ALU_SLTU;
         3'b100:  code = ALU_XOR;
         3'b101:  code = alt ? ALU_SRA : ALU_SRL;
         3'b110:  code = ALU_OR;
         default: code = ALU_AND;
      endcase
      return code;
   endfunction

   // EQ/GE/GEU are taken when the compare result is zero; the rest when nonzero
   function automatic logic br_taken(input br_e br_type, input logic zero);
      logic taken;
      case (br_type)
         BR_EQ, BR_GE, BR_GEU: taken = zero;
         default:              taken = !zero;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode for OP, OP-IMM and BRANCH into ALU control,
// operand-B source, destination and branch metadata; anything else is illegal.
module alu_decode
   import alu_issue_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic [3:0]  alu_ctrl_o,
   output bsel_e       bsel_o,
   output logic [4:0]  rd_o,
   output logic        we_o,
   output logic        branch_o,
   output br_e         br_type_o,
   output logic        illegal_o
);

   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [2:0] funct3;
   logic       is_shift;
   logic       unused_operand_fields;

   assign opcode   = instr_i[6:0];
   assign funct3   = instr_i[14:12];
   assign funct7   = instr_i[31:25];
   assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
   // rs1/rs2 specifiers and the immediate are consumed by the issue stage
   assign unused_operand_fields = ^instr_i[24:15];

   always_comb begin
      alu_ctrl_o = ALU_ADD;
      bsel_o     = BSEL_RS2;
      rd_o       = 5'd0;
      we_o       = 1'b0;
      branch_o   = 1'b0;
      br_type_o  = BR_EQ;
      illegal_o  = 1'b1;
      case (opcode)
         OPC_OP: begin
            if ((funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
               illegal_o  = 1'b0;
               rd_o       = instr_i[11:7];
               we_o       = (instr_i[11:7] != 5'd0);
               alu_ctrl_o = alu_code(funct3, funct7[5]);
               bsel_o     = is_shift ? BSEL_SHAMT_RS2 : BSEL_RS2;
            end
         end
         OPC_OP_IMM: begin
            // upper immediate bits are free except on shifts, where they are funct7
            if (!is_shift || (funct7 == 7'b0000000) ||
                ((funct3 == 3'b101) && (funct7 == 7'b0100000))) begin
               illegal_o  = 1'b0;
               rd_o       = instr_i[11:7];
               we_o       = (instr_i[11:7] != 5'd0);
               alu_ctrl_o = alu_code(funct3, is_shift & funct7[5]);
               bsel_o     = is_shift ? BSEL_SHAMT_IMM : BSEL_IMM;
            end
         end
         OPC_BRANCH: begin
            illegal_o = 1'b0;
            branch_o  = 1'b1;
            case (funct3)
               3'b000:  begin alu_ctrl_o = ALU_SUB;  br_type_o = BR_EQ;  end
               3'b001:  begin alu_ctrl_o = ALU_SUB;  br_type_o = BR_NE;  end
               3'b100:  begin alu_ctrl_o = ALU_SLT;  br_type_o = BR_LT;  end
               3'b101:  begin alu_ctrl_o = ALU_SLT;  br_type_o = BR_GE;  end
               3'b110:  begin alu_ctrl_o = ALU_SLTU; br_type_o = BR_LTU; end
               3'b111:  begin alu_ctrl_o = ALU_SLTU; br_type_o = BR_GEU; end
               default: begin illegal_o = 1'b1; branch_o = 1'b0; end
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_issue.sv
// Issue stage feeding an external combinational ALU: latches operands, waits
// one cycle for the ALU, then holds the captured result until consumed.
//   state | meaning
//   IDLE  | empty, ready for an instruction
//   EXEC  | operands on ALU ports, result captured at the next edge
//   HOLD  | result presented with out_valid until out_ready
module alu_issue
   import alu_issue_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_rs1,
   input  logic [31:0] in_rs2,
   input  logic        flush,
   output logic [31:0] alu_in_a,
   output logic [31:0] alu_in_b,
   output logic [3:0]  alu_control,
   input  logic [31:0] alu_result,
   input  logic        zero_flag,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [4:0]  out_rd,
   output logic        out_we,
   output logic        out_branch,
   output logic        out_taken,
   output logic        out_illegal
);

   state_e      state_q, state_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [4:0]  rd_q, rd_d;
   logic        we_q, we_d, br_q, br_d, ill_q, ill_d;
   br_e         brt_q, brt_d;
   logic [31:0] res_q, res_d;
   logic [4:0]  ord_q, ord_d;
   logic        owe_q, owe_d, obr_q, obr_d, otk_q, otk_d, oill_q, oill_d;

   logic [3:0]  dec_ctrl;
   bsel_e       dec_bsel;
   logic [4:0]  dec_rd;
   logic        dec_we, dec_branch, dec_illegal;
   br_e         dec_br_type;
   logic [31:0] b_sel;
   logic        accept;

   alu_decode u_decode (
      .instr_i    (in_instr),
      .alu_ctrl_o (dec_ctrl),
      .bsel_o     (dec_bsel),
      .rd_o       (dec_rd),
      .we_o       (dec_we),
      .branch_o   (dec_branch),
      .br_type_o  (dec_br_type),
      .illegal_o  (dec_illegal)
   );

   always_comb begin
      b_sel = in_rs2;
      case (dec_bsel)
         BSEL_IMM:       b_sel = {{20{in_instr[31]}}, in_instr[31:20]};
         BSEL_SHAMT_IMM: b_sel = {27'd0, in_instr[24:20]};
         BSEL_SHAMT_RS2: b_sel = {27'd0, in_rs2[4:0]};
         default:        b_sel = in_rs2;
      endcase
   end

   assign in_ready = !flush && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      ctrl_d  = ctrl_q;
      rd_d    = rd_q;
      we_d    = we_q;
      br_d    = br_q;
      brt_d   = brt_q;
      ill_d   = ill_q;
      res_d   = res_q;
      ord_d   = ord_q;
      owe_d   = owe_q;
      obr_d   = obr_q;
      otk_d   = otk_q;
      oill_d  = oill_q;
      if (flush) begin
         state_d = IDLE;
         res_d   = 32'd0;
         ord_d   = 5'd0;
         owe_d   = 1'b0;
         obr_d   = 1'b0;
         otk_d   = 1'b0;
         oill_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: begin
               res_d   = ill_q ? 32'd0 : alu_result;
               ord_d   = rd_q;
               owe_d   = we_q;
               obr_d   = br_q;
               otk_d   = br_q && br_taken(brt_q, zero_flag);
               oill_d  = ill_q;
               state_d = HOLD;
            end
            HOLD: if (out_ready) state_d = in_valid ? EXEC : IDLE;
            default: state_d = IDLE;
         endcase
         if (accept) begin
            a_d    = in_rs1;
            b_d    = b_sel;
            ctrl_d = dec_ctrl;
            rd_d   = dec_rd;
            we_d   = dec_we;
            br_d   = dec_branch;
            brt_d  = dec_br_type;
            ill_d  = dec_illegal;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         ctrl_q  <= ALU_ADD;
         rd_q    <= 5'd0;
         we_q    <= 1'b0;
         br_q    <= 1'b0;
         brt_q   <= BR_EQ;
         ill_q   <= 1'b0;
         res_q   <= 32'd0;
         ord_q   <= 5'd0;
         owe_q   <= 1'b0;
         obr_q   <= 1'b0;
         otk_q   <= 1'b0;
         oill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ctrl_q  <= ctrl_d;
         rd_q    <= rd_d;
         we_q    <= we_d;
         br_q    <= br_d;
         brt_q   <= brt_d;
         ill_q   <= ill_d;
         res_q   <= res_d;
         ord_q   <= ord_d;
         owe_q   <= owe_d;
         obr_q   <= obr_d;
         otk_q   <= otk_d;
         oill_q  <= oill_d;
      end
   end

   assign alu_in_a    = a_q;
   assign alu_in_b    = b_q;
   assign alu_control = ctrl_q;
   assign out_valid   = (state_q == HOLD);
   assign out_result  = res_q;
   assign out_rd      = ord_q;
   assign out_we      = owe_q;
   assign out_branch  = obr_q;
   assign out_taken   = otk_q;
   assign out_illegal = oill_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: a model ALU closes the loop, an instruction-level
// reference predicts each result, and a negedge monitor compares what the DUT presents.
module tb_alu_issue;

   localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_SUB = 4'b0100;
   localparam logic [3:0] C_SLT = 4'b1000, C_SLL = 4'b0011, C_SRL = 4'b0101, C_SLTU = 4'b0110;
   localparam logic [3:0] C_XOR = 4'b0111, C_SRA = 4'b1001;

   logic        clk, rst_n, in_valid, in_ready, flush, zero_flag;
   logic [31:0] in_instr, in_rs1, in_rs2, alu_in_a, alu_in_b, alu_result, out_result;
   logic [3:0]  alu_control;
   logic        out_valid, out_ready, out_we, out_branch, out_taken, out_illegal;
   logic [4:0]  out_rd;

   typedef struct {
      logic [3:0]  ctrl;
      logic [31:0] a, b, res;
      logic [4:0]  rd;
      logic        we, br, tk, ill;
   } exp_t;

   exp_t alu_q[$];
   exp_t out_q[$];
   exp_t h_alu, h_out;
   int   total = 0;
   int   bad = 0;
   logic acc_pend = 1'b0;
   logic rand_ready = 1'b0;

   alu_issue dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2), .flush(flush),
      .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_control(alu_control),
      .alu_result(alu_result), .zero_flag(zero_flag), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd), .out_we(out_we),
      .out_branch(out_branch), .out_taken(out_taken), .out_illegal(out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model ALU on the return path
   always_comb begin
      alu_result = 32'd0;
      case (alu_control)
         C_AND:  alu_result = alu_in_a & alu_in_b;
         C_OR:   alu_result = alu_in_a | alu_in_b;
         C_ADD:  alu_result = alu_in_a + alu_in_b;
         C_SUB:  alu_result = alu_in_a - alu_in_b;
         C_SLT:  alu_result = 32'($signed(alu_in_a) < $signed(alu_in_b));
         C_SLTU: alu_result = 32'(alu_in_a < alu_in_b);
         C_SLL:  alu_result = alu_in_a << alu_in_b[4:0];
         C_SRL:  alu_result = alu_in_a >> alu_in_b[4:0];
         C_SRA:  alu_result = 32'($signed(alu_in_a) >>> alu_in_b[4:0]);
         C_XOR:  alu_result = alu_in_a ^ alu_in_b;
         default: alu_result = 32'd0;
      endcase
   end
   assign zero_flag = (alu_result == 32'd0);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // RV32I meaning of an arithmetic funct3 with its ALU code
   function automatic logic [35:0] sem(input logic [2:0] f3, input logic alt,
                                       input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0:    return alt ? {C_SUB, a - b} : {C_ADD, a + b};
         3'd1:    return {C_SLL, a << b[4:0]};
         3'd2:    return {C_SLT, 32'($signed(a) < $signed(b))};
         3'd3:    return {C_SLTU, 32'(a < b)};
         3'd4:    return {C_XOR, a ^ b};
         3'd5:    return alt ? {C_SRA, 32'($signed(a) >>> b[4:0])} : {C_SRL, a >> b[4:0]};
         3'd6:    return {C_OR, a | b};
         default: return {C_AND, a & b};
      endcase
   endfunction

   function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] r1,
                                      input logic [31:0] r2);
      exp_t e;
      logic [6:0] op, f7;
      logic [2:0] f3;
      logic shift;
      op = ins[6:0]; f7 = ins[31:25]; f3 = ins[14:12];
      shift = (f3 == 3'd1) || (f3 == 3'd5);
      e = '{ctrl: C_ADD, a: r1, b: r2, res: 32'd0, rd: 5'd0, we: 1'b0, br: 1'b0, tk: 1'b0, ill: 1'b1};
      if (op == 7'h33 && (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) begin
         e.ill = 1'b0; e.rd = ins[11:7]; e.we = (ins[11:7] != 5'd0);
         if (shift) e.b = {27'd0, r2[4:0]};
         {e.ctrl, e.res} = sem(f3, f7[5], r1, r2);
      end else if (op == 7'h13 && !(f3 == 3'd1 && f7 != 7'h00) &&
                   !(f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) begin
         e.ill = 1'b0; e.rd = ins[11:7]; e.we = (ins[11:7] != 5'd0);
         e.b = shift ? {27'd0, ins[24:20]} : {{20{ins[31]}}, ins[31:20]};
         {e.ctrl, e.res} = sem(f3, shift & f7[5], r1, e.b);
      end else if (op == 7'h63 && f3 != 3'd2 && f3 != 3'd3) begin
         e.ill = 1'b0; e.br = 1'b1;
         case (f3)
            3'd0:    begin e.ctrl = C_SUB;  e.res = r1 - r2; e.tk = (r1 == r2); end
            3'd1:    begin e.ctrl = C_SUB;  e.res = r1 - r2; e.tk = (r1 != r2); end
            3'd4:    begin e.ctrl = C_SLT;  e.res = 32'($signed(r1) < $signed(r2)); e.tk = ($signed(r1) < $signed(r2)); end
            3'd5:    begin e.ctrl = C_SLT;  e.res = 32'($signed(r1) < $signed(r2)); e.tk = ($signed(r1) >= $signed(r2)); end
            3'd6:    begin e.ctrl = C_SLTU; e.res = 32'(r1 < r2); e.tk = (r1 < r2); end
            default: begin e.ctrl = C_SLTU; e.res = 32'(r1 < r2); e.tk = (r1 >= r2); end
         endcase
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      int k;
      logic [6:0] op, f7;
      k = $urandom_range(0, 9);
      op = (k < 4) ? 7'h33 : (k < 7) ? 7'h13 : (k < 9) ? 7'h63 : 7'($urandom);
      case ($urandom_range(0, 3))
         0, 1:    f7 = 7'h00;
         2:       f7 = 7'h20;
         default: f7 = 7'($urandom);
      endcase
      return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), op};
   endfunction

   // caller is just past a rising edge; returns just past the accepting edge
   task automatic issue(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                        output int waits);
      exp_t e;
      e = ref_model(ins, r1, r2);
      in_valid = 1'b1; in_instr = ins; in_rs1 = r1; in_rs2 = r2; waits = 0;
      @(negedge clk);
      while (!in_ready && waits < 60) begin
         waits++;
         @(negedge clk);
      end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL issue_timeout: in_ready got 0 after %0d cycles, required 1", waits);
      end else begin
         alu_q.push_back(e);
         out_q.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         alu_q.delete(); out_q.delete(); acc_pend = 1'b0;
      end else begin
         if (acc_pend) begin
            if (alu_q.size() == 0) begin
               total++; bad++;
               $display("FAIL alu_unexpected: got an accept, required none pending");
            end else begin
               h_alu = alu_q.pop_front();
               check("alu_in_a", alu_in_a, h_alu.a);
               check("alu_in_b", alu_in_b, h_alu.b);
               check("alu_control", 32'(alu_control), 32'(h_alu.ctrl));
            end
         end
         if (out_valid) begin
            if (out_q.size() == 0) begin
               total++; bad++;
               $display("FAIL out_unexpected: got out_valid=1, required 0");
            end else begin
               h_out = out_q[0];
               check("out_result", out_result, h_out.res);
               check("out_rd", 32'(out_rd), 32'(h_out.rd));
               check("out_we", 32'(out_we), 32'(h_out.we));
               check("out_branch", 32'(out_branch), 32'(h_out.br));
               check("out_taken", 32'(out_taken), 32'(h_out.tk));
               check("out_illegal", 32'(out_illegal), 32'(h_out.ill));
               if (out_ready) void'(out_q.pop_front());
            end
         end
         acc_pend = in_valid && in_ready;
         if (flush) begin
            alu_q.delete(); out_q.delete(); acc_pend = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation still running at time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, n;
      logic [31:0] r1, r2;
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_instr = 32'd0; in_rs1 = 32'd0; in_rs2 = 32'd0;
      @(negedge clk); @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_alu_control", 32'(alu_control), 32'(C_ADD));
      check("rst_alu_in_a", alu_in_a, 32'd0);
      check("rst_alu_in_b", alu_in_b, 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_we", 32'(out_we), 32'd0);
      @(posedge clk); #1; rst_n = 1'b1;

      // ADD x3, x1, x2 with latency check
      issue({7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33}, 32'd5, 32'd7, w);
      @(negedge clk); check("add_exec_no_valid", 32'(out_valid), 32'd0);
      @(negedge clk); check("add_valid_after_2", 32'(out_valid), 32'd1);
      check("add_result", out_result, 32'd12);
      check("add_rd", 32'(out_rd), 32'd3);
      tick(2);

      // SRAI x2, x1, 4
      issue({7'h20, 5'd4, 5'd1, 3'd5, 5'd2, 7'h13}, 32'h8000_0000, 32'd0, w);
      @(negedge clk);
      check("srai_b", alu_in_b, 32'd4);
      check("srai_ctrl", 32'(alu_control), 32'(C_SRA));
      tick(2);

      // ADDI x4, x1, -1
      issue({12'hFFF, 5'd1, 3'd0, 5'd4, 7'h13}, 32'd1, 32'd0, w);
      @(negedge clk); check("addi_b", alu_in_b, 32'hFFFF_FFFF);
      @(negedge clk); check("addi_result", out_result, 32'd0);
      tick(2);

      // BNE with equal operands
      issue({7'h00, 5'd2, 5'd1, 3'd1, 5'd0, 7'h63}, 32'd9, 32'd9, w);
      @(negedge clk);
      check("bne_ctrl", 32'(alu_control), 32'(C_SUB));
      check("bne_zero", 32'(zero_flag), 32'd1);
      @(negedge clk);
      check("bne_taken", 32'(out_taken), 32'd0);
      check("bne_branch", 32'(out_branch), 32'd1);
      check("bne_we", 32'(out_we), 32'd0);
      tick(2);

      // BGE 3 >= 2
      issue({7'h00, 5'd2, 5'd1, 3'd5, 5'd0, 7'h63}, 32'd3, 32'd2, w);
      @(negedge clk); @(negedge clk);
      check("bge_taken", 32'(out_taken), 32'd1);
      tick(2);

      // backpressure: five stalled HOLD cycles, then release with a same-cycle accept
      out_ready = 1'b0;
      issue({7'h00, 5'd7, 5'd6, 3'd4, 5'd9, 7'h33}, 32'hA5A5_0F0F, 32'h0FF0_1234, w);
      @(negedge clk);
      repeat (5) begin
         @(negedge clk);
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1; out_ready = 1'b1;
      issue({7'h20, 5'd2, 5'd1, 3'd0, 5'd5, 7'h33}, 32'd10, 32'd3, w);
      check("stall_release_same_cycle", 32'(w), 32'd0);
      tick(3);

      // flush while in EXEC
      issue({7'h00, 5'd2, 5'd1, 3'd6, 5'd8, 7'h33}, 32'd1, 32'd2, w);
      flush = 1'b1;
      @(negedge clk); check("flush_exec_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1; flush = 1'b0;
      repeat (3) begin @(negedge clk); check("flush_exec_no_valid", 32'(out_valid), 32'd0); end
      tick(1);

      // flush in HOLD beats a ready handshake
      out_ready = 1'b0;
      issue({7'h00, 5'd2, 5'd1, 3'd7, 5'd8, 7'h33}, 32'd6, 32'd3, w);
      tick(1);
      flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
      in_instr = {7'h00, 5'd2, 5'd1, 3'd0, 5'd8, 7'h33};
      @(negedge clk); check("flush_hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
      @(negedge clk); check("flush_hold_dropped", 32'(out_valid), 32'd0);
      tick(1);

      // reset pulse during HOLD
      out_ready = 1'b0;
      issue({7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33}, 32'd1, 32'd1, w);
      @(posedge clk); #1;
      check("pre_reset_hold", 32'(out_valid), 32'd1);
      #1; rst_n = 1'b0; #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1; rst_n = 1'b1; out_ready = 1'b1;
      repeat (3) begin @(negedge clk); check("reset_no_valid", 32'(out_valid), 32'd0); end
      tick(1);

      // illegal opcode
      issue({25'h1234A, 7'h7F}, 32'd4, 32'd5, w);
      @(negedge clk); @(negedge clk);
      check("illegal_flag", 32'(out_illegal), 32'd1);
      check("illegal_we", 32'(out_we), 32'd0);
      tick(2);

      // randomized traffic with random backpressure and occasional flush
      rand_ready = 1'b1;
      repeat (300) begin
         r1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
         r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
         issue(rand_instr(), r1, r2, w);
         if ($urandom_range(0, 19) == 0) begin
            flush = 1'b1;
            @(posedge clk); #1; flush = 1'b0;
         end
         tick($urandom_range(0, 2));
      end
      rand_ready = 1'b0;
      @(posedge clk); #2; out_ready = 1'b1;
      n = 0;
      while (out_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", 32'(out_q.size()), 32'd0);
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The module SHALL declare ports in this order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  unit can accept.
- in_instr  in  32  RV32I instruction word.
- in_rs1  in  32  rs1 value.
- in_rs2  in  32  rs2 value.
- flush  in  1  synchronous kill of all in-flight work.
- alu_in_a  out  32  ALU operand A (registered).
- alu_in_b  out  32  ALU operand B (registered).
- alu_control  out  4  ALU opcode (registered).
- alu_result  in  32  ALU result, combinational return.
- zero_flag  in  1  ALU zero flag, combinational return.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_result  out  32  captured ALU result.
- out_rd  out  5  destination register.
- out_we  out  1  register write enable (0 for branches and rd=x0).
- out_branch  out  1  result belongs to a branch.
- out_taken  out  1  branch condition true.
- out_illegal  out  1  instruction not decodable by this unit.

Function
REQ-002 The unit SHALL use ALU codes AND=0000, OR=0001, ADD=0010, SUB=0100, SLT=1000, SLL=0011, SRL=0101, SLTU=0110, XOR=0111, SRA=1001.
REQ-003 Decode SHALL cover OP (0110011), OP-IMM (0010011) and BRANCH (1100011), with funct7[5] selecting SUB over ADD and SRA over SRL.
REQ-004 OP-IMM SHALL drive alu_in_b with the sign-extended imm[11:0], except shifts, which SHALL use zero-extended imm[4:0].
REQ-005 For register shifts, alu_in_b SHALL be rs2[4:0], zero-extended.
REQ-006 BRANCH mapping SHALL be: BEQ/BNE->SUB, BLT/BGE->SLT, BLTU/BGEU->SLTU.
- out_taken = zero_flag for BEQ.
- out_taken = !zero_flag for BNE, BLT and BLTU.
- out_taken = zero_flag for BGE and BGEU.
REQ-007 Any other opcode/funct combination SHALL complete as illegal.
- out_illegal=1, out_we=0, out_result=0, alu_control=ADD.
REQ-008 The FSM states SHALL be IDLE, EXEC and HOLD.
- IDLE: in_ready=1; on in_valid, register operands, alu_control and metadata -> EXEC.
- EXEC: capture alu_result, zero_flag and derived out_taken into output registers -> HOLD.
- HOLD: out_valid=1; on out_ready, if in_valid accept the next instruction -> EXEC, else -> IDLE.
REQ-009 in_ready SHALL be 1 in IDLE and in HOLD while out_ready=1, and 0 otherwise.
REQ-010 Latency SHALL be: accept at edge N, ALU operands valid after N, out_valid after N+1.
- Back-to-back sustained throughput is one result per 2 cycles.
REQ-011 Output registers SHALL remain stable while out_valid=1 and out_ready=0.
REQ-012 flush SHALL force IDLE at the next edge, drop the held result and deassert out_valid, with priority over all handshakes.
- in_ready is 0 during the flush cycle.
REQ-013 out_we SHALL be 0 when rd=0, for branches, and for illegal instructions.

Reset
REQ-014 While rst_n=0, the unit SHALL be in state IDLE with every output register at 0, except alu_control=0010.
- Consequence: in_ready=1 and out_valid=0.
REQ-015 Reset asserted mid-EXEC or mid-HOLD SHALL discard the instruction without producing out_valid after release.

Structure
REQ-016 A shared package SHALL hold the ALU code constants, the RV32I opcode constants and the FSM state enum.
REQ-017 Decode SHALL be a combinational sub-module alu_decode (instr -> control, operand-B select, rd, we, branch type, illegal); FSM and registers stay in alu_issue.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- ADD x3, rs1=5, rs2=7 -> alu_control=0010, out_result=12, out_rd=3, out_we=1, out_valid 2 edges after accept.
- SRAI imm=4, rs1=0x80000000 -> alu_in_b=4, alu_control=1001.
- ADDI imm=0xFFF, rs1=1 -> alu_in_b=0xFFFFFFFF, with a model ALU out_result=0.
- BNE with rs1=rs2=9 -> SUB, zero_flag=1, out_taken=0, out_branch=1, out_we=0.
- BGE with rs1=3, rs2=2 (ALU SLT result 0) -> out_taken=1.
- out_ready held 0 for 5 cycles in HOLD -> outputs stable and in_ready=0; then out_ready=1 with in_valid=1 accepts the next instruction in the same cycle.
- flush in EXEC -> no out_valid.
- rst_n pulsed low in HOLD -> out_valid=0 immediately and in_ready=1.
- Opcode 0x7F -> out_illegal=1, out_we=0.
